mem_port_arbiter: RTL

Shares the single SRAM-like memory bus between the instruction-fetch port and the data port of the 5-stage MIPS pipeline.
Sequences one outstanding transaction at a time, giving priority to data, which is the older instruction in M.
Generates the i_stall / d_stall inputs consumed by the hazard unit.
Holds each completed result until the whole pipeline advances, so a fetch or load is never reissued while stalled by the other port or the divider.

---
 rtl/mem_port_arbiter_pkg.sv | 33 +++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the memory-port arbiter of the 5-stage MIPS pipeline:
// the arbiter state encoding, the bus access-size codes and the bus field
// widths. Imported by mem_port_arbiter and by anything that drives or observes
// the shared SRAM-like bus.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Width of the bus_size / d_size field.
  localparam int BUS_SIZE_W = 2;

  // Access-size codes carried on d_size / bus_size.
  localparam logic [BUS_SIZE_W-1:0] SIZE_B = 2'd0;  // byte
  localparam logic [BUS_SIZE_W-1:0] SIZE_H = 2'd1;  // halfword
  localparam logic [BUS_SIZE_W-1:0] SIZE_W = 2'd2;  // word

  // Arbiter states. Explicit 3-bit encodings so the state register is stable
  // across tool versions and readable in waveforms.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_ADDR = 3'd1,
    ST_D_DATA = 3'd2,
    ST_I_ADDR = 3'd3,
    ST_I_DATA = 3'd4
  } arb_state_e;

  // True in the states that drive the address phase on the bus.
  function automatic logic is_addr_phase(input arb_state_e s);
    return (s == ST_D_ADDR) || (s == ST_I_ADDR);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one SRAM-like memory bus between the instruction-fetch port (F stage)
// and the data port (M stage). One transaction is outstanding at a time; the
// data port wins when both are waiting because it belongs to the older
// instruction. Each completed result is held (with a done flag) until the whole
// pipeline advances, so a fetch or load is never reissued while the pipeline is
// stalled by the other port or by the divider.
//
// Ports
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   i_req/i_addr  fetch request (level) and address
//   i_rdata       fetched instruction, valid while the fetch is done
//   i_stall       i_req & ~fetch_done, to the hazard unit
//   d_req/d_wr/d_size/d_addr/d_wdata
//                 load/store request (level) and its fields
//   d_rdata       load data, valid while the data access is done
//   d_stall       d_req & ~data_done, to the hazard unit
//   div_stall     divider busy; blocks the pipeline advance
//   bus_req       address-phase request, held until bus_addr_ok
//   bus_wr/bus_size/bus_addr/bus_wdata
//                 transaction fields, latched when the transaction starts
//   bus_addr_ok   address phase accepted
//   bus_data_ok   data phase complete; bus_rdata valid with it
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction-fetch port
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_stall,
  // data port
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [BUS_SIZE_W-1:0] d_size,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_stall,
  // pipeline
  input  logic                  div_stall,
  // memory bus
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [BUS_SIZE_W-1:0] bus_size,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata
);

  arb_state_e state;
  arb_state_e state_nxt;

  logic i_done;     // fetch result held in i_rdata for the current instruction
  logic d_done;     // load/store completed for the current instruction
  logic advance;    // whole pipeline moves this cycle
  logic start_d;    // leaving IDLE towards a data transaction
  logic start_i;    // leaving IDLE towards a fetch transaction
  logic i_complete; // fetch data phase finishes this cycle
  logic d_complete; // data-port data phase finishes this cycle

  // ---------------------------------------------------------------------------
  // Stall and advance. A port stalls only while it requests and has not yet
  // completed for the current instruction.
  // ---------------------------------------------------------------------------
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;
  assign advance = ~i_stall & ~d_stall & ~div_stall;

  assign start_d    = (state == ST_IDLE) && (state_nxt == ST_D_ADDR);
  assign start_i    = (state == ST_IDLE) && (state_nxt == ST_I_ADDR);
  assign i_complete = (state == ST_I_DATA) && bus_data_ok;
  assign d_complete = (state == ST_D_DATA) && bus_data_ok;

  // Address phase is a pure decode of the state, so it drops with the state
  // on reset and never needs its own register.
  assign bus_req = is_addr_phase(state);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The data port is checked first: it is the older
  // instruction and must not be starved by a stream of fetches. bus_addr_ok
  // and bus_data_ok only matter in the state that waits for them.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (d_req && !d_done) begin
          state_nxt = ST_D_ADDR;
        end else if (i_req && !i_done) begin
          state_nxt = ST_I_ADDR;
        end
      end
      ST_D_ADDR: if (bus_addr_ok) state_nxt = ST_D_DATA;
      ST_D_DATA: if (bus_data_ok) state_nxt = ST_IDLE;
      ST_I_ADDR: if (bus_addr_ok) state_nxt = ST_I_DATA;
      ST_I_DATA: if (bus_data_ok) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction field latch. Fields are captured once when the transaction
  // starts and stay stable through both bus phases. Fetches are word reads.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_wr    <= 1'b0;
      bus_size  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (start_d) begin
      bus_wr    <= d_wr;
      bus_size  <= d_size;
      bus_addr  <= d_addr;
      bus_wdata <= d_wdata;
    end else if (start_i) begin
      bus_wr    <= 1'b0;
      bus_size  <= SIZE_W;
      bus_addr  <= i_addr;
      bus_wdata <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Result-hold registers and done flags.
  // A completing port is stalled in its completion cycle, so advance is
  // normally 0 there. The exception is a request dropped while in flight
  // (flush): the result is still captured and the flag then waits for the
  // following advance, hence the completion assignments come last.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (advance) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
      // NOTE: for the same register the last non-blocking assignment in the
      // block wins, so a completion overrides the advance clear above.
      if (i_complete) begin
        i_done  <= 1'b1;
        i_rdata <= bus_rdata;
      end
      if (d_complete) begin
        d_done <= 1'b1;
        // Stores complete the port but leave the last load value in place.
        if (!bus_wr) d_rdata <= bus_rdata;
      end
    end
  end

endmodule
